// File: rtl/pbc_pkg.sv
// Shared encodings and defaults for the pbcount family of event counters.
package pbc_pkg;

  localparam logic PBC_MODE_WRAP = 1'b0;
  localparam logic PBC_MODE_SAT  = 1'b1;
  localparam logic PBC_DIR_DOWN  = 1'b0;
  localparam logic PBC_DIR_UP    = 1'b1;

  localparam int PBC_DEF_WIDTH = 4;

endpackage

// File: rtl/pbc_edge_sync.sv
// Synchronises an async event line into syclk and emits a one-cycle evt per rising edge.
// Latency: evt is high SYNC_STAGES cycles after the first edge that samples si high; no backpressure.
module pbc_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic syclk,
  input  logic srst,
  input  logic si,
  output logic evt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge syclk or posedge srst) begin
    if (srst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], si};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // prev_q clears in reset, so a line held high through release yields one edge
  assign evt = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/pbcount.sv
// Up/down event counter with load, wrap/saturate, tc and ovf; compare output under PBCOUNT_CMP_EN.
// Latency: sfo/ovf update SYNC_STAGES+1 cycles after si is first sampled high; no backpressure.
module pbcount import pbc_pkg::*; #(
  parameter int               WIDTH       = PBC_DEF_WIDTH,
  parameter logic [WIDTH-1:0] MAX_VAL     = '1,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             syclk,
  input  logic             srst,
  input  logic             si,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             ld,
  input  logic [WIDTH-1:0] ldval,
`ifdef PBCOUNT_CMP_EN
  input  logic [WIDTH-1:0] cmpval,
  output logic             cmp,
`endif
  output logic [WIDTH-1:0] sfo,
  output logic             tc,
  output logic             ovf
);

  logic             evt;
  logic [WIDTH-1:0] nxt_sfo;
  logic             nxt_ovf;

  pbc_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .syclk (syclk),
    .srst  (srst),
    .si    (si),
    .evt   (evt)
  );

  always_comb begin
    nxt_sfo = sfo;
    nxt_ovf = 1'b0;
    if (ld) begin
      nxt_sfo = (ldval > MAX_VAL) ? MAX_VAL : ldval;
    end else if (evt && en) begin
      if (dir == PBC_DIR_UP) begin
        if (sfo >= MAX_VAL) begin
          nxt_ovf = 1'b1;
          nxt_sfo = (mode == PBC_MODE_SAT) ? MAX_VAL : '0;
        end else begin
          nxt_sfo = sfo + 1'b1;
        end
      end else begin
        if (sfo == '0) begin
          nxt_ovf = 1'b1;
          nxt_sfo = (mode == PBC_MODE_SAT) ? '0 : MAX_VAL;
        end else begin
          nxt_sfo = sfo - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge syclk or posedge srst) begin
    if (srst) begin
      sfo <= '0;
      ovf <= 1'b0;
    end else begin
      sfo <= nxt_sfo;
      ovf <= nxt_ovf;
    end
  end

  assign tc = (dir == PBC_DIR_UP) ? (sfo == MAX_VAL) : (sfo == '0);

`ifdef PBCOUNT_CMP_EN
  // compares against the next value so cmp lines up with the sfo it describes
  always_ff @(posedge syclk or posedge srst) begin
    if (srst) cmp <= 1'b0;
    else      cmp <= (nxt_sfo == cmpval);
  end
`else
  // compare feature not built
`endif

endmodule

// File: tb/tb_pbcount.sv
// Directed bench for pbcount: u0 full range (0..15), u1 clamped range (0..9), shared stimulus.
module tb_pbcount;
  import pbc_pkg::*;

  logic       syclk = 1'b0;
  logic       srst, si, en, dir, mode, ld;
  logic [3:0] ldval;
  logic [3:0] sfo0, sfo1;
  logic       tc0, tc1, ovf0, ovf1;
`ifdef PBCOUNT_CMP_EN
  logic [3:0] cmpval;
  logic       cmp0, cmp1;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 syclk = ~syclk;

  pbcount #(.WIDTH(4), .SYNC_STAGES(2)) u0 (
    .syclk(syclk), .srst(srst), .si(si), .en(en), .dir(dir), .mode(mode),
    .ld(ld), .ldval(ldval),
`ifdef PBCOUNT_CMP_EN
    .cmpval(cmpval), .cmp(cmp0),
`endif
    .sfo(sfo0), .tc(tc0), .ovf(ovf0)
  );

  pbcount #(.WIDTH(4), .MAX_VAL(4'd9), .SYNC_STAGES(2)) u1 (
    .syclk(syclk), .srst(srst), .si(si), .en(en), .dir(dir), .mode(mode),
    .ld(ld), .ldval(ldval),
`ifdef PBCOUNT_CMP_EN
    .cmpval(cmpval), .cmp(cmp1),
`endif
    .sfo(sfo1), .tc(tc1), .ovf(ovf1)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge syclk);
    #1;
  endtask

  // one-cycle si pulse; returns on the cycle the resulting count is visible
  task automatic event_pulse();
    si = 1'b1;
    tick();
    si = 1'b0;
    tick();
    tick();
  endtask

  task automatic load(input logic [3:0] v);
    ldval = v;
    ld    = 1'b1;
    tick();
    ld    = 1'b0;
  endtask

  initial begin
    srst = 1'b1; si = 1'b0; en = 1'b1; dir = PBC_DIR_DOWN; mode = PBC_MODE_WRAP;
    ld = 1'b0; ldval = '0;
`ifdef PBCOUNT_CMP_EN
    cmpval = 4'd5;
`endif
    tick();
    tick();
    chk("rst_sfo", sfo0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_tc_down", tc0, 1);
    dir = PBC_DIR_UP;
    #1;
    chk("rst_tc_up", tc0, 0);
    srst = 1'b0;
    tick();

    // 1: latency SYNC_STAGES+1
    si = 1'b1;
    tick();
    chk("lat_c1", sfo0, 0);
    si = 1'b0;
    tick();
    chk("lat_c2", sfo0, 0);
    tick();
    chk("lat_c3", sfo0, 1);
    chk("lat_ovf", ovf0, 0);
    tick();
    chk("lat_hold", sfo0, 1);

    // en=0 drops the event
    en = 1'b0;
    event_pulse();
    tick();
    chk("en_drop", sfo0, 1);
    en = 1'b1;

    // 2: wrap up from 14
    mode = PBC_MODE_WRAP; dir = PBC_DIR_UP;
    load(4'd14);
    chk("wrap_ld", sfo0, 14);
    chk("wrap_ld_tc", tc0, 0);
    chk("wrap_ld_clamp_u1", sfo1, 9);
    event_pulse();
    chk("wrap_e1", sfo0, 15);
    chk("wrap_e1_ovf", ovf0, 0);
    chk("wrap_e1_tc", tc0, 1);
    event_pulse();
    chk("wrap_e2", sfo0, 0);
    chk("wrap_e2_ovf", ovf0, 1);
    chk("wrap_e2_tc", tc0, 0);
    tick();
    chk("wrap_ovf_1cyc", ovf0, 0);
    event_pulse();
    chk("wrap_e3", sfo0, 1);
    chk("wrap_e3_ovf", ovf0, 0);

    // 3: saturate down from 1
    mode = PBC_MODE_SAT; dir = PBC_DIR_DOWN;
    load(4'd1);
    chk("sat_ld", sfo0, 1);
    chk("sat_ld_tc", tc0, 0);
    event_pulse();
    chk("sat_e1", sfo0, 0);
    chk("sat_e1_ovf", ovf0, 0);
    chk("sat_e1_tc", tc0, 1);
    event_pulse();
    chk("sat_e2", sfo0, 0);
    chk("sat_e2_ovf", ovf0, 1);
    event_pulse();
    chk("sat_e3", sfo0, 0);
    chk("sat_e3_ovf", ovf0, 1);
    chk("sat_e3_tc", tc0, 1);

    // 4: load beats coincident event, clamped to MAX_VAL=9 on u1
    mode = PBC_MODE_WRAP; dir = PBC_DIR_UP;
    load(4'd2);
    si = 1'b1;
    tick();
    si = 1'b0;
    tick();
    load(4'd12);
    chk("prio_u1", sfo1, 9);
    chk("prio_u1_ovf", ovf1, 0);
    chk("prio_u0", sfo0, 12);
    chk("prio_u1_tc", tc1, 1);
    tick();
    tick();
    chk("prio_lost", sfo1, 9);
    event_pulse();
    chk("clamp_wrap", sfo1, 0);
    chk("clamp_wrap_ovf", ovf1, 1);
    chk("clamp_u0", sfo0, 13);

    // 5: reset between si rise and sfo update
    load(4'd3);
    si = 1'b1;
    tick();
    si = 1'b0;
    tick();
    srst = 1'b1;
    #1;
    chk("arst_sfo", sfo0, 0);
    chk("arst_ovf", ovf0, 0);
    tick();
    srst = 1'b0;
    tick(); tick(); tick(); tick();
    chk("arst_no_count", sfo0, 0);
    // si high across release: exactly one count, SYNC_STAGES+1 edges later
    srst = 1'b1;
    si   = 1'b1;
    tick();
    srst = 1'b0;
    tick();
    tick();
    chk("held_c2", sfo0, 0);
    tick();
    chk("held_c3", sfo0, 1);
    tick(); tick(); tick();
    chk("held_once", sfo0, 1);
    si = 1'b0;
    tick(); tick(); tick();
    chk("held_fall", sfo0, 1);

`ifdef PBCOUNT_CMP_EN
    // 6: compare tracks sfo with no extra cycle
    cmpval = 4'd5;
    load(4'd0);
    chk("cmp_ld0", cmp0, 0);
    for (int i = 1; i <= 6; i++) begin
      event_pulse();
      chk($sformatf("cmp_sfo%0d", i), sfo0, i);
      chk($sformatf("cmp_at%0d", i), cmp0, (i == 5) ? 1 : 0);
    end
    load(4'd5);
    chk("cmp_ld5", cmp0, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
